// File: rtl/life_frame_reader.sv
// life_frame_reader: snapshots the Game-of-Life grid and streams it out one row per valid/ready beat.
// Define LIFE_FRAME_POPCOUNT_EN to build the per-frame live-cell counter driving pop/pop_valid.
module life_frame_reader #(
    parameter int N   = 23,
    parameter int FCW = 16,
    parameter int PW  = 10
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N*N-1:0]   cells,
    input  logic             snap_req,
    output logic             busy,
    output logic [N-1:0]     out_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic [FCW-1:0]   frame_cnt,
    output logic             overrun,
    output logic [PW-1:0]    pop,
    output logic             pop_valid
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           r_state;
    logic [N*N-1:0]   r_snap;
    logic [IW-1:0]    r_idx;
    logic [N-1:0]     r_row;
    logic             r_sof;
    logic             r_eof;
    logic [FCW-1:0]   r_frame_cnt;
    logic             r_overrun;

    logic             w_accept;
    logic             w_last;
    logic [IW-1:0]    w_nxt;

    assign w_accept = (r_state == SEND) && out_ready;
    assign w_last   = w_accept && (r_idx == LAST);
    assign w_nxt    = r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_snap      <= '0;
            r_idx       <= '0;
            r_row       <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (snap_req && r_state == SEND)
                r_overrun <= 1'b1;
            if (r_state == IDLE && snap_req) begin
                r_snap  <= cells;
                r_idx   <= '0;
                r_row   <= cells[N-1:0];
                r_sof   <= 1'b1;
                r_eof   <= (N == 1);
                r_state <= SEND;
            end else if (w_last) begin
                r_state     <= IDLE;
                r_idx       <= '0;
                r_sof       <= 1'b0;
                r_eof       <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end else if (w_accept) begin
                // Preload the next row so out_row never depends on out_ready combinationally
                r_idx <= w_nxt;
                r_row <= r_snap[int'(w_nxt)*N +: N];
                r_sof <= 1'b0;
                r_eof <= (w_nxt == LAST);
            end
        end
    end

    assign busy      = (r_state == SEND);
    assign out_valid = (r_state == SEND);
    assign out_row   = r_row;
    assign out_sof   = r_sof;
    assign out_eof   = r_eof;
    assign frame_cnt = r_frame_cnt;
    assign overrun   = r_overrun;

`ifdef LIFE_FRAME_POPCOUNT_EN
    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_pop;
    logic          r_pop_valid;
    logic [PW-1:0] w_row_pop;
    logic [PW-1:0] w_sum;

    always_comb begin
        w_row_pop = '0;
        for (int i = 0; i < N; i++)
            w_row_pop = w_row_pop + PW'(r_row[i]);
    end

    // Row 0 restarts the running total so a previously abandoned frame never leaks in
    assign w_sum = (r_sof ? '0 : r_acc) + w_row_pop;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_acc       <= '0;
            r_pop       <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_last;
            if (w_accept)
                r_acc <= w_sum;
            if (w_last)
                r_pop <= w_sum;
        end
    end

    assign pop       = r_pop;
    assign pop_valid = r_pop_valid;
`else
    assign pop       = '0;
    assign pop_valid = 1'b0;
`endif
endmodule

// File: tb/tb_life_frame_reader.sv
// tb_life_frame_reader: directed checks of capture, streaming, backpressure, overrun, reset and counter wrap.
module tb_life_frame_reader;
    localparam int N   = 23;
    localparam int NN  = N * N;
    localparam int FCW = 2;
    localparam int PW  = 10;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [NN-1:0]   cells = '0;
    logic            snap_req = 1'b0;
    logic            busy;
    logic [N-1:0]    out_row;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_sof;
    logic            out_eof;
    logic [FCW-1:0]  frame_cnt;
    logic            overrun;
    logic [PW-1:0]   pop;
    logic            pop_valid;

    int              ncmp = 0;
    int              nerr = 0;
    logic [FCW-1:0]  exp_fc = '0;
    logic            exp_ovr = 1'b0;
    logic [NN-1:0]   g;
    logic [NN-1:0]   gexp;
    logic [NN-1:0]   s;

    life_frame_reader #(.N(N), .FCW(FCW), .PW(PW)) dut (
        .clk(clk), .nrst(nrst), .cells(cells), .snap_req(snap_req), .busy(busy),
        .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt),
        .overrun(overrun), .pop(pop), .pop_valid(pop_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NN-1:0] obs, input logic [NN-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] row_of(input logic [NN-1:0] v, input int r);
        return v[r*N +: N];
    endfunction

    function automatic logic [NN-1:0] rand_grid();
        logic [NN-1:0] v;
        for (int k = 0; k < NN; k++) v[k] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic start(input logic [NN-1:0] v);
        cells = v;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // Streams expected rows of v; optionally applies backpressure, churns cells, fires extra requests, or stops early
    task automatic run_frame(input logic [NN-1:0] v, input bit bp, input bit chg,
                             input int req_beat, input bit req_last, input int stop_at);
        int r;
        int guard;
        r = 0;
        guard = 0;
        while (r < N) begin
            if (r == stop_at) return;
            chk("valid", out_valid, 1'b1);
            chk("busy", busy, 1'b1);
            chk($sformatf("row%0d", r), out_row, row_of(v, r));
            chk("sof", out_sof, r == 0);
            chk("eof", out_eof, r == N - 1);
            chk("pop_valid_low", pop_valid, 1'b0);
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (chg) cells = rand_grid();
            snap_req = (r == req_beat) || (req_last && r == N - 1 && out_ready);
            if (out_ready) r++;
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                ncmp++;
                nerr++;
                $error("FAIL timeout: got %0d rows want %0d", r, N);
                break;
            end
        end
        snap_req = 1'b0;
        out_ready = 1'b1;
        exp_fc++;
        if (req_beat >= 0 || req_last) exp_ovr = 1'b1;
        chk("end_valid", out_valid, 1'b0);
        chk("end_busy", busy, 1'b0);
        chk("end_sof", out_sof, 1'b0);
        chk("end_eof", out_eof, 1'b0);
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("overrun", overrun, exp_ovr);
`ifdef LIFE_FRAME_POPCOUNT_EN
        chk("pop_valid", pop_valid, 1'b1);
        chk("pop", pop, PW'($countones(v)));
`else
        chk("pop_valid", pop_valid, 1'b0);
        chk("pop", pop, '0);
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_row", out_row, '0);
        chk("rst_sof", out_sof, 1'b0);
        chk("rst_eof", out_eof, 1'b0);
        chk("rst_frame_cnt", frame_cnt, '0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_pop", pop, '0);
        chk("rst_pop_valid", pop_valid, 1'b0);
        nrst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        g = '0;
        g[45] = 1'b1; g[46] = 1'b1; g[47] = 1'b1; g[53] = 1'b1; g[61] = 1'b1;
        gexp = '0;
        gexp[N +: N]   = 23'h400000;
        gexp[2*N +: N] = 23'h008083;
        start(g);
        run_frame(gexp, 1'b0, 1'b0, -1, 1'b0, -1);
        @(negedge clk);
        chk("pop_pulse_once", pop_valid, 1'b0);

        s = rand_grid();
        start(s);
        run_frame(s, 1'b1, 1'b1, -1, 1'b0, -1);

        s = rand_grid();
        start(s);
        run_frame(s, 1'b0, 1'b0, 5, 1'b1, -1);
        @(negedge clk);
        chk("no_second_frame", out_valid, 1'b0);
        chk("overrun_sticky", overrun, 1'b1);

        s = rand_grid();
        start(s);
        run_frame(s, 1'b0, 1'b0, -1, 1'b0, 10);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        exp_fc = '0;
        exp_ovr = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_eof", out_eof, 1'b0);
        chk("mid_rst_frame_cnt", frame_cnt, '0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_pop", pop, '0);
        chk("mid_rst_pop_valid", pop_valid, 1'b0);
        s = rand_grid();
        start(s);
        run_frame(s, 1'b0, 1'b0, -1, 1'b0, -1);

        start({NN{1'b1}});
        run_frame({NN{1'b1}}, 1'b0, 1'b0, -1, 1'b0, -1);

        for (int f = 0; f < 3; f++) begin
            s = rand_grid();
            start(s);
            run_frame(s, 1'b1, 1'b0, -1, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
